pc_sequencer: RTL and testbench

- Fetch sequencer for the 8-bit instruction ROM.
- Owns the program counter that addresses the ROM.
- Selects which stored program runs (product, string match, closest pair) and advances, branches or stalls the PC under datapath control.
- Detects the halt opcode and enforces a cycle-limit watchdog; reports run status to the testbench/top level.

---
 rtl/pc_sequencer.sv | 139 +++++++++++++
 tb/tb_pc_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch sequencer for the 8-bit instruction ROM: owns the program counter,
// launches one of three stored programs, and tracks halt / watchdog status.
`timescale 1ns/1ps
module pc_sequencer #(
    parameter logic [7:0]  PROG0_BASE = 8'h00,
    parameter logic [7:0]  PROG1_BASE = 8'h3D,
    parameter logic [7:0]  PROG2_BASE = 8'h6D,
    parameter logic [7:0]  HALT_OP    = 8'b00000010,
    parameter logic [15:0] MAX_CYCLES = 16'd4096
) (
    input  logic        clck,
    input  logic        reset,
    input  logic        start_i,
    input  logic [1:0]  prog_sel_i,
    input  logic        abort_i,
    input  logic        stall_i,
    input  logic [7:0]  instr_i,
    input  logic        branch_taken_i,
    input  logic [7:0]  branch_target_i,
    output logic [7:0]  pc_o,
    output logic        instr_valid_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        timeout_o,
    output logic        sel_err_o,
    output logic [15:0] cycle_cnt_o,
    output logic [15:0] retired_cnt_o,
    output logic [1:0]  state_dbg_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [7:0]  pc_n;
    logic [15:0] cyc_n, ret_n;
    logic        done_n, timeout_n, sel_err_n;

    logic        in_run, can_start, start_ok, start_bad;
    logic        halt_ret, wd_hit;
    logic [15:0] cyc_inc, ret_inc;
    logic [7:0]  base_addr;

    // Counters saturate rather than wrap so a runaway run never looks short.
    assign cyc_inc = (cycle_cnt_o == 16'hFFFF) ? cycle_cnt_o : cycle_cnt_o + 16'd1;
    assign ret_inc = (retired_cnt_o == 16'hFFFF) ? retired_cnt_o : retired_cnt_o + 16'd1;

    assign in_run    = (state == S_RUN);
    assign can_start = ((state == S_IDLE) || (state == S_HALTED && !abort_i)) && start_i;
    assign start_ok  = can_start && (prog_sel_i != 2'd3);
    assign start_bad = can_start && (prog_sel_i == 2'd3);
    assign halt_ret  = in_run && !abort_i && !stall_i && (instr_i == HALT_OP);
    assign wd_hit    = in_run && !abort_i && !halt_ret && (cyc_inc >= MAX_CYCLES);

    always_comb begin
        base_addr = PROG0_BASE;
        case (prog_sel_i)
            2'd1:    base_addr = PROG1_BASE;
            2'd2:    base_addr = PROG2_BASE;
            default: base_addr = PROG0_BASE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clck or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            pc_o          <= 8'h00;
            cycle_cnt_o   <= 16'd0;
            retired_cnt_o <= 16'd0;
            done_o        <= 1'b0;
            timeout_o     <= 1'b0;
            sel_err_o     <= 1'b0;
        end else begin
            state         <= state_n;
            pc_o          <= pc_n;
            cycle_cnt_o   <= cyc_n;
            retired_cnt_o <= ret_n;
            done_o        <= done_n;
            timeout_o     <= timeout_n;
            sel_err_o     <= sel_err_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (start_ok) state_n = S_RUN;
            end
            S_RUN: begin
                if (abort_i)       state_n = S_IDLE;
                else if (halt_ret) state_n = S_HALTED;
                else if (wd_hit)   state_n = S_HALTED;
            end
            S_HALTED: begin
                if (abort_i)       state_n = S_IDLE;
                else if (start_ok) state_n = S_RUN;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // The watchdog cycle still retires its instruction; it only ends the run.
    always_comb begin
        pc_n      = pc_o;
        cyc_n     = cycle_cnt_o;
        ret_n     = retired_cnt_o;
        done_n    = 1'b0;
        timeout_n = timeout_o;
        sel_err_n = sel_err_o;
        if (start_ok) begin
            pc_n      = base_addr;
            cyc_n     = 16'd0;
            ret_n     = 16'd0;
            timeout_n = 1'b0;
            sel_err_n = 1'b0;
        end
        if (start_bad) sel_err_n = 1'b1;
        if (in_run && !abort_i) begin
            cyc_n = cyc_inc;
            if (!stall_i) begin
                ret_n = ret_inc;
                if (halt_ret)            done_n = 1'b1;
                else if (branch_taken_i) pc_n = branch_target_i;
                else                     pc_n = pc_o + 8'd1;
            end
            if (wd_hit) timeout_n = 1'b1;
        end
    end

    assign instr_valid_o = in_run && !stall_i;
    assign busy_o        = in_run;
    assign state_dbg_o   = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a default-limit instance runs the ROM
// programs, a second instance with a 16-cycle watchdog covers timeouts.
`timescale 1ns/1ps
module tb_pc_sequencer;

    localparam logic [7:0] HALT = 8'b00000010;

    logic        clck = 1'b0;
    logic        reset = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  prog_sel_i = 2'd0;
    logic        abort_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [7:0]  branch_target_i = 8'h00;
    logic        use_rom = 1'b1;
    logic [7:0]  instr_drv = 8'h11;
    logic [7:0]  instr_i;

    logic [7:0]  pc_o;
    logic        instr_valid_o, busy_o, done_o, timeout_o, sel_err_o;
    logic [15:0] cycle_cnt_o, retired_cnt_o;
    logic [1:0]  state_dbg_o;

    logic [7:0]  w_pc;
    logic        w_valid, w_busy, w_done, w_timeout, w_sel_err;
    logic [15:0] w_cyc, w_ret;
    logic [1:0]  w_state;

    int checks = 0;
    int failures = 0;

    always #5 clck = ~clck;

    // ROM model: program 0 halts at 8'h3C, everything else is a plain opcode.
    function automatic logic [7:0] rom(input logic [7:0] a);
        return (a == 8'h3C) ? HALT : 8'h11;
    endfunction

    assign instr_i = use_rom ? rom(pc_o) : instr_drv;

    pc_sequencer dut (
        .clck(clck), .reset(reset), .start_i(start_i), .prog_sel_i(prog_sel_i),
        .abort_i(abort_i), .stall_i(stall_i), .instr_i(instr_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .pc_o(pc_o), .instr_valid_o(instr_valid_o), .busy_o(busy_o), .done_o(done_o),
        .timeout_o(timeout_o), .sel_err_o(sel_err_o), .cycle_cnt_o(cycle_cnt_o),
        .retired_cnt_o(retired_cnt_o), .state_dbg_o(state_dbg_o)
    );

    pc_sequencer #(.MAX_CYCLES(16'd16)) wd (
        .clck(clck), .reset(reset), .start_i(start_i), .prog_sel_i(prog_sel_i),
        .abort_i(abort_i), .stall_i(stall_i), .instr_i(instr_drv),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .pc_o(w_pc), .instr_valid_o(w_valid), .busy_o(w_busy), .done_o(w_done),
        .timeout_o(w_timeout), .sel_err_o(w_sel_err), .cycle_cnt_o(w_cyc),
        .retired_cnt_o(w_ret), .state_dbg_o(w_state)
    );

    // All tasks are entered at a falling edge and leave at a falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clck);
    endtask

    task automatic start_prog(input logic [1:0] sel);
        start_i = 1'b1; prog_sel_i = sel;
        step(1);
        start_i = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #1;
        checks++; if (pc_o !== 8'h00) begin failures++; $display("FAIL rst_pc: got %h exp 00", pc_o); end
        checks++; if ({busy_o, done_o, timeout_o, sel_err_o} !== 4'b0000) begin failures++; $display("FAIL rst_flags: got %b exp 0000", {busy_o, done_o, timeout_o, sel_err_o}); end
        checks++; if ({cycle_cnt_o, retired_cnt_o} !== 32'd0) begin failures++; $display("FAIL rst_cnt: got %h exp 0", {cycle_cnt_o, retired_cnt_o}); end
        checks++; if (state_dbg_o !== 2'd0) begin failures++; $display("FAIL rst_state: got %0d exp 0", state_dbg_o); end
        step(1);
        reset = 1'b1;
        step(1);
    endtask

    task automatic test_prog0;
        int n;
        start_prog(2'd0);
        checks++; if (pc_o !== 8'h00 || busy_o !== 1'b1) begin failures++; $display("FAIL p0_first: got pc=%h busy=%b exp pc=00 busy=1", pc_o, busy_o); end
        checks++; if (instr_valid_o !== 1'b1) begin failures++; $display("FAIL p0_valid: got %b exp 1", instr_valid_o); end
        n = 0;
        while (!done_o && n < 100) begin
            step(1);
            n++;
            if (!done_o) begin
                checks++; if (pc_o !== n[7:0]) begin failures++; $display("FAIL p0_walk: got %h exp %h", pc_o, n[7:0]); end
            end
        end
        checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL p0_done: got %b exp 1 after %0d cycles", done_o, n); end
        checks++; if (pc_o !== 8'h3C || busy_o !== 1'b0) begin failures++; $display("FAIL p0_halt: got pc=%h busy=%b exp pc=3c busy=0", pc_o, busy_o); end
        checks++; if (retired_cnt_o !== 16'd61 || cycle_cnt_o !== 16'd61) begin failures++; $display("FAIL p0_cnt: got ret=%0d cyc=%0d exp 61/61", retired_cnt_o, cycle_cnt_o); end
        step(1);
        checks++; if (done_o !== 1'b0 || pc_o !== 8'h3C) begin failures++; $display("FAIL p0_pulse: got done=%b pc=%h exp 0/3c", done_o, pc_o); end
    endtask

    task automatic test_branch;
        start_prog(2'd0);
        step(22);
        checks++; if (pc_o !== 8'h16) begin failures++; $display("FAIL br_reach: got %h exp 16", pc_o); end
        branch_taken_i = 1'b1; branch_target_i = 8'h1C;
        step(1);
        branch_taken_i = 1'b0;
        checks++; if (pc_o !== 8'h1C || retired_cnt_o !== 16'd23) begin failures++; $display("FAIL br_jump: got pc=%h ret=%0d exp 1c/23", pc_o, retired_cnt_o); end
        abort_i = 1'b1;
        step(1);
        abort_i = 1'b0;
        checks++; if (state_dbg_o !== 2'd0 || pc_o !== 8'h1C || done_o !== 1'b0 || retired_cnt_o !== 16'd23) begin
            failures++; $display("FAIL br_abort: got st=%0d pc=%h done=%b ret=%0d exp 0/1c/0/23", state_dbg_o, pc_o, done_o, retired_cnt_o); end
        start_prog(2'd0);
        step(22);
        use_rom = 1'b0; instr_drv = HALT;
        branch_taken_i = 1'b1; branch_target_i = 8'h1C;
        step(1);
        branch_taken_i = 1'b0; use_rom = 1'b1; instr_drv = 8'h11;
        checks++; if (state_dbg_o !== 2'd2 || pc_o !== 8'h16 || done_o !== 1'b1) begin
            failures++; $display("FAIL br_halt_wins: got st=%0d pc=%h done=%b exp 2/16/1", state_dbg_o, pc_o, done_o); end
        checks++; if (retired_cnt_o !== 16'd23) begin failures++; $display("FAIL br_halt_ret: got %0d exp 23", retired_cnt_o); end
    endtask

    task automatic test_stall;
        start_prog(2'd0);
        step(5);
        checks++; if (pc_o !== 8'h05 || cycle_cnt_o !== 16'd5 || retired_cnt_o !== 16'd5) begin
            failures++; $display("FAIL st_pre: got pc=%h cyc=%0d ret=%0d exp 05/5/5", pc_o, cycle_cnt_o, retired_cnt_o); end
        stall_i = 1'b1; use_rom = 1'b0; instr_drv = HALT;
        #1;
        checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL st_valid: got %b exp 0", instr_valid_o); end
        step(3);
        checks++; if (pc_o !== 8'h05 || cycle_cnt_o !== 16'd8 || retired_cnt_o !== 16'd5) begin
            failures++; $display("FAIL st_hold: got pc=%h cyc=%0d ret=%0d exp 05/8/5", pc_o, cycle_cnt_o, retired_cnt_o); end
        checks++; if (busy_o !== 1'b1 || done_o !== 1'b0) begin failures++; $display("FAIL st_nohalt: got busy=%b done=%b exp 1/0", busy_o, done_o); end
        stall_i = 1'b0; use_rom = 1'b1; instr_drv = 8'h11;
        #1;
        checks++; if (instr_valid_o !== 1'b1) begin failures++; $display("FAIL st_resume_valid: got %b exp 1", instr_valid_o); end
        step(1);
        checks++; if (pc_o !== 8'h06 || cycle_cnt_o !== 16'd9 || retired_cnt_o !== 16'd6) begin
            failures++; $display("FAIL st_resume: got pc=%h cyc=%0d ret=%0d exp 06/9/6", pc_o, cycle_cnt_o, retired_cnt_o); end
    endtask

    task automatic test_sel;
        abort_i = 1'b1;
        step(1);
        abort_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL sel_idle: got busy=%b exp 0", busy_o); end
        start_prog(2'd3);
        checks++; if (sel_err_o !== 1'b1 || busy_o !== 1'b0 || pc_o !== 8'h06) begin
            failures++; $display("FAIL sel_bad: got err=%b busy=%b pc=%h exp 1/0/06", sel_err_o, busy_o, pc_o); end
        start_prog(2'd1);
        checks++; if (sel_err_o !== 1'b0 || busy_o !== 1'b1 || pc_o !== 8'h3D || retired_cnt_o !== 16'd0) begin
            failures++; $display("FAIL sel_p1: got err=%b busy=%b pc=%h ret=%0d exp 0/1/3d/0", sel_err_o, busy_o, pc_o, retired_cnt_o); end
        start_prog(2'd2);
        checks++; if (pc_o !== 8'h3E || busy_o !== 1'b1 || retired_cnt_o !== 16'd1) begin
            failures++; $display("FAIL sel_ignore: got pc=%h busy=%b ret=%0d exp 3e/1/1", pc_o, busy_o, retired_cnt_o); end
    endtask

    task automatic test_wrap_reset;
        branch_taken_i = 1'b1; branch_target_i = 8'hFF;
        step(1);
        branch_taken_i = 1'b0;
        checks++; if (pc_o !== 8'hFF) begin failures++; $display("FAIL wr_ff: got %h exp ff", pc_o); end
        step(1);
        checks++; if (pc_o !== 8'h00) begin failures++; $display("FAIL wr_wrap: got %h exp 00", pc_o); end
        step(1);
        @(posedge clck);
        #2 reset = 1'b0;
        #1;
        checks++; if (pc_o !== 8'h00 || busy_o !== 1'b0 || state_dbg_o !== 2'd0) begin
            failures++; $display("FAIL ar_state: got pc=%h busy=%b st=%0d exp 00/0/0", pc_o, busy_o, state_dbg_o); end
        checks++; if ({cycle_cnt_o, retired_cnt_o} !== 32'd0 || done_o !== 1'b0) begin
            failures++; $display("FAIL ar_cnt: got cyc=%0d ret=%0d done=%b exp 0/0/0", cycle_cnt_o, retired_cnt_o, done_o); end
        @(negedge clck);
        reset = 1'b1;
        step(1);
    endtask

    task automatic test_watchdog;
        logic seen_done;
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        instr_drv = 8'h11; branch_taken_i = 1'b1; branch_target_i = 8'h00;
        start_prog(2'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            if (w_done) seen_done = 1'b1;
        end
        checks++; if (w_busy !== 1'b1 || w_timeout !== 1'b0 || w_cyc !== 16'd15) begin
            failures++; $display("FAIL wd_pre: got busy=%b to=%b cyc=%0d exp 1/0/15", w_busy, w_timeout, w_cyc); end
        step(1);
        if (w_done) seen_done = 1'b1;
        checks++; if (w_timeout !== 1'b1 || w_busy !== 1'b0 || w_cyc !== 16'd16 || w_state !== 2'd2) begin
            failures++; $display("FAIL wd_fire: got to=%b busy=%b cyc=%0d st=%0d exp 1/0/16/2", w_timeout, w_busy, w_cyc, w_state); end
        step(2);
        if (w_done) seen_done = 1'b1;
        checks++; if (seen_done !== 1'b0 || w_timeout !== 1'b1) begin
            failures++; $display("FAIL wd_nodone: got done_seen=%b to=%b exp 0/1", seen_done, w_timeout); end
        start_prog(2'd0);
        checks++; if (w_timeout !== 1'b0 || w_busy !== 1'b1) begin failures++; $display("FAIL wd_clear: got to=%b busy=%b exp 0/1", w_timeout, w_busy); end
        step(15);
        instr_drv = HALT;
        step(1);
        instr_drv = 8'h11; branch_taken_i = 1'b0;
        checks++; if (w_done !== 1'b1 || w_timeout !== 1'b0 || w_busy !== 1'b0) begin
            failures++; $display("FAIL wd_halt_wins: got done=%b to=%b busy=%b exp 1/0/0", w_done, w_timeout, w_busy); end
        checks++; if (w_ret !== 16'd16 || w_cyc !== 16'd16) begin failures++; $display("FAIL wd_halt_cnt: got ret=%0d cyc=%0d exp 16/16", w_ret, w_cyc); end
    endtask

    initial begin
        @(negedge clck);
        test_reset();
        test_prog0();
        test_branch();
        test_stall();
        test_sel();
        test_wrap_reset();
        test_watchdog();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule
